// File: rtl/fetch_buf.sv
// Instruction fetch buffer: one I-cache request per cycle into an in-order slot queue, oldest filled slot to decode.
// Define FETCH_BUF_BYPASS_EN to forward a response for the head slot straight to decode in the same cycle.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef Disable_
`define Disable_ 1'b1
`endif

module fetch_buf #(
    parameter int              ADDR     = `AddrWidth,
    parameter int              INST     = `InstWidth,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic [ADDR-1:0] next_fetch_pc,
    output logic [ADDR-1:0] fetch_pc,
    output logic            fetch_stall_,
    output logic            ic_req_,
    output logic [ADDR-1:0] ic_addr,
    input  logic            ic_ready,
    input  logic            ic_resp_e_,
    input  logic [INST-1:0] ic_inst,
    input  logic            flush_,
    input  logic            dec_stall_,
    output logic            inst_e_,
    output logic [ADDR-1:0] inst_pc,
    output logic [INST-1:0] inst
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR-1:0] pc;
        logic [INST-1:0] inst;
        logic            filled;
    } slot_t;

    slot_t         slots [DEPTH];
    slot_t         head;
    logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
    logic [CW-1:0] used, pend, discard;
    logic          req_v, accept, resp_v, fill_v, head_rdy, byp, present, deq, fill_wr;

    always_comb begin
        head     = slots[head_ptr];
        req_v    = reset_ && flush_ && (used < FULL);
        accept   = req_v && ic_ready;
        resp_v   = (ic_resp_e_ == `Enable_);
        // responses owed to squashed requests are swallowed before any slot is filled
        fill_v   = resp_v && flush_ && (discard == '0);
        head_rdy = (used != '0) && head.filled;
`ifdef FETCH_BUF_BYPASS_EN
        byp      = (used != '0) && !head.filled && (fill_ptr == head_ptr) && (discard == '0) && resp_v;
`else
        byp      = 1'b0;
`endif
        present  = head_rdy || byp;
        deq      = present && (dec_stall_ == `Disable_);
        fill_wr  = fill_v && !(byp && deq);
    end

    assign fetch_stall_ = accept ? `Disable_ : `Enable_;
    assign ic_req_      = req_v ? `Enable_ : `Disable_;
    assign ic_addr      = fetch_pc;
    assign inst_e_      = present ? `Enable_ : `Disable_;
    assign inst_pc      = head.pc;
    assign inst         = byp ? ic_inst : head.inst;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            pend      <= '0;
            discard   <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (!flush_) begin
            fetch_pc  <= next_fetch_pc;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            pend      <= '0;
            // every response still owed by the cache (old and new) must now be dropped
            discard   <= discard + pend - CW'(resp_v);
            for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
        end else begin
            if (accept) begin
                slots[alloc_ptr].pc     <= fetch_pc;
                slots[alloc_ptr].filled <= 1'b0;
                alloc_ptr               <= alloc_ptr + 1'b1;
                fetch_pc                <= next_fetch_pc;
            end
            if (fill_wr) begin
                slots[fill_ptr].inst   <= ic_inst;
                slots[fill_ptr].filled <= 1'b1;
            end
            if (fill_v) fill_ptr <= fill_ptr + 1'b1;
            if (deq) head_ptr <= head_ptr + 1'b1;
            if (resp_v && (discard != '0)) discard <= discard - 1'b1;
            used <= used + CW'(accept) - CW'(deq);
            pend <= pend + CW'(accept) - CW'(fill_v);
        end
    end

`ifndef SYNTHESIS
    a_orphan_resp: assert property (@(posedge clk) disable iff (!reset_)
        !(resp_v && (pend == '0) && (discard == '0)));
    a_used_range: assert property (@(posedge clk) disable iff (!reset_) used <= FULL);
`endif

endmodule

// File: tb/tb_fetch_buf.sv
// Scoreboard bench for fetch_buf: random fetch/decode/cache traffic against a queue-level reference model.
module tb_fetch_buf;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk, reset_;
    logic [31:0] next_fetch_pc, fetch_pc, ic_addr, ic_inst, inst_pc, inst;
    logic        fetch_stall_, ic_req_, ic_ready, ic_resp_e_, flush_, dec_stall_, inst_e_;

    fetch_buf #(.ADDR(32), .INST(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_(reset_), .next_fetch_pc(next_fetch_pc), .fetch_pc(fetch_pc),
        .fetch_stall_(fetch_stall_), .ic_req_(ic_req_), .ic_addr(ic_addr), .ic_ready(ic_ready),
        .ic_resp_e_(ic_resp_e_), .ic_inst(ic_inst), .flush_(flush_), .dec_stall_(dec_stall_),
        .inst_e_(inst_e_), .inst_pc(inst_pc), .inst(inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { logic [31:0] addr; int cyc; int epoch; } ce_t;

    // exp_q: accepted, not yet delivered (oldest first); the first n_filled have their response
    exp_t        exp_q[$];
    ce_t         cache_q[$];
    ce_t         ce;
    int          n_filled, epoch, cyc, n_chk, n_pass, n_deliv;
    logic [31:0] m_pc;
    bit          m_accept, mon_ran, byp_taken, mon_req, mon_vld, mon_byp;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_reset_vals();
        chk("rst fetch_pc", fetch_pc, RESET_PC);
        chk("rst ic_req_", ic_req_, 1);
        chk("rst fetch_stall_", fetch_stall_, 0);
        chk("rst inst_e_", inst_e_, 1);
        chk("rst inst_pc", inst_pc, 0);
        chk("rst inst", inst, 0);
    endtask

    // monitor: compares DUT outputs with the model before this cycle's updates, pops deliveries
    always @(negedge clk) begin
        if (reset_) begin
            mon_req = (exp_q.size() < DEPTH) && flush_;
            mon_vld = (exp_q.size() > 0) && (n_filled > 0);
            mon_byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
            mon_byp = (exp_q.size() > 0) && (n_filled == 0) && !ic_resp_e_ &&
                      (cache_q.size() > 0) && (cache_q[0].epoch == epoch);
`endif
            chk("fetch_pc", fetch_pc, m_pc);
            chk("ic_req_", ic_req_, !mon_req);
            if (mon_req) chk("ic_addr", ic_addr, m_pc);
            chk("fetch_stall_", fetch_stall_, mon_req && ic_ready);
            chk("inst_e_", inst_e_, !(mon_vld || mon_byp));
            if (mon_vld || mon_byp) begin
                chk("inst_pc", inst_pc, exp_q[0].pc);
                chk("inst", inst, exp_q[0].inst);
                if (dec_stall_) begin
                    void'(exp_q.pop_front());
                    if (n_filled > 0) n_filled--;
                    else byp_taken = 1'b1;
                    n_deliv++;
                end
            end
            m_accept = mon_req && ic_ready;
            mon_ran  = 1'b1;
        end
    end

    // reference model update: response, then flush or request issue
    always @(negedge clk) begin
        #4;
        if (reset_ && mon_ran) begin
            mon_ran = 1'b0;
            if (!ic_resp_e_ && cache_q.size() > 0) begin
                ce = cache_q.pop_front();
                if (ce.epoch == epoch && !byp_taken && n_filled < exp_q.size()) n_filled++;
            end
            byp_taken = 1'b0;
            if (!flush_) begin
                exp_q.delete();
                n_filled = 0;
                epoch++;
                m_pc = next_fetch_pc;
            end else if (m_accept) begin
                exp_q.push_back('{pc: m_pc, inst: inst_of(m_pc)});
                cache_q.push_back('{addr: ic_addr, cyc: cyc, epoch: epoch});
                m_pc = next_fetch_pc;
            end
        end
    end

    // one cycle of fetch_iag / decode / I-cache behaviour; percentages 0..100
    task automatic cycle(input int dec_pct, input int fl_pct, input int rdy_pct, input int rsp_pct,
                         input logic [31:0] tgt);
        @(posedge clk);
        cyc++;
        #1;
        dec_stall_ = ($urandom_range(99) < dec_pct);
        flush_     = !($urandom_range(99) < fl_pct);
        ic_ready   = ($urandom_range(99) < rdy_pct) && (cache_q.size() < DEPTH);
        if (!flush_) next_fetch_pc = (tgt != 0) ? tgt : ($urandom & 32'h0000_FFFC);
        else next_fetch_pc = m_pc + 32'd4;
        if (cache_q.size() > 0 && cache_q[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
            ic_resp_e_ = 1'b0;
            ic_inst    = inst_of(cache_q[0].addr);
        end else begin
            ic_resp_e_ = 1'b1;
            ic_inst    = $urandom;
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3 reset_ = 1'b0;
        #1 chk_reset_vals();
        exp_q.delete();
        cache_q.delete();
        n_filled  = 0;
        epoch++;
        m_pc      = RESET_PC;
        byp_taken = 1'b0;
        mon_ran   = 1'b0;
        ic_ready  = 1'b0;
        ic_resp_e_ = 1'b1;
        flush_    = 1'b1;
        dec_stall_ = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset_ = 1'b1;
    endtask

    initial begin
        reset_ = 1'b0; ic_ready = 1'b0; ic_resp_e_ = 1'b1; flush_ = 1'b1; dec_stall_ = 1'b1;
        next_fetch_pc = '0; ic_inst = '0;
        n_filled = 0; epoch = 0; cyc = 0; n_chk = 0; n_pass = 0; n_deliv = 0;
        m_pc = RESET_PC; m_accept = 1'b0; mon_ran = 1'b0; byp_taken = 1'b0;
        #3 chk_reset_vals();
        @(posedge clk);
        #2 reset_ = 1'b1;

        repeat (20) cycle(100, 0, 100, 100, 0);   // straight-line streaming
        repeat (8)  cycle(0, 0, 100, 0, 0);       // decode stalled, cache silent: fill up
        repeat (20) cycle(100, 0, 100, 100, 0);   // drain and refill
        repeat (3)  cycle(100, 0, 0, 100, 0);     // cache not ready
        repeat (5)  cycle(100, 0, 100, 100, 0);
        repeat (10) cycle(100, 0, 0, 100, 0);     // drain everything
        repeat (3)  cycle(0, 0, 100, 0, 0);       // three requests outstanding
        cycle(0, 100, 0, 0, 32'h100);             // redirect to 0x100
        repeat (20) cycle(100, 0, 100, 100, 0);
        repeat (1500) cycle(70, 4, 80, 60, 0);
        mid_reset();
        repeat (10) cycle(100, 0, 100, 100, 0);
        repeat (1500) cycle(50, 3, 70, 70, 0);
        chk("deliveries", n_deliv >= 300, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_buf.md
Name: fetch_buf

Overview:
- Instruction fetch buffer between fetch_iag and decode.
- Issues one I-cache request per cycle at the current fetch PC and reserves an in-order queue slot per request.
- Fills each slot when its response returns and presents the oldest filled slot to decode.
- Drives fetch_pc / fetch_stall_ back to fetch_iag and squashes all state and in-flight requests on a writeback flush.

Parameters:
- ADDR, `AddrWidth, PC/address width
- INST, `InstWidth, instruction width
- DEPTH, 4, queue slots (power of two, ≥2); bounds outstanding requests
- RESET_PC, 0, fetch PC after reset

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- next_fetch_pc  in  ADDR  next PC from fetch_iag (redirect target when flush_ low)
- fetch_pc  out  ADDR  PC currently being requested
- fetch_stall_  out  1  low = request not accepted this cycle; fetch_iag holds
- ic_req_  out  1  low = I-cache request valid
- ic_addr  out  ADDR  request address (= fetch_pc)
- ic_ready  in  1  high = cache accepts request this cycle
- ic_resp_e_  in  1  low = response valid, strictly in request order
- ic_inst  in  INST  response instruction
- flush_  in  1  low = flush (from wb_flush_)
- dec_stall_  in  1  low = decode cannot accept
- inst_e_  out  1  low = inst/inst_pc valid to decode
- inst_pc  out  ADDR  PC of presented instruction
- inst  out  INST  presented instruction

Behaviour:
- Reset (async, reset_ low): fetch_pc=RESET_PC; all pointers, counters and discard count 0; ic_req_=`Disable_; inst_e_=`Disable_; inst_pc=0; inst=0; fetch_stall_=`Enable_.
- State: slot array {pc, inst, filled}; alloc_ptr, fill_ptr and head_ptr, each $clog2(DEPTH) bits, with wrap; used counter of $clog2(DEPTH)+1 bits (0..DEPTH); discard counter of the same width.
- Request: ic_req_=`Enable_ when used<DEPTH and flush_ high. Accept = ic_req_ low & ic_ready.
- On accept: slot[alloc_ptr] gets pc=fetch_pc, filled=0; alloc_ptr++; fetch_pc<=next_fetch_pc.
- fetch_stall_ = `Disable_ iff accept, combinational.
- Response (ic_resp_e_ low, discard==0): slot[fill_ptr] gets inst, filled=1; fill_ptr++.
- Response while discard>0: dropped; discard--.
- Output: inst_e_ low iff used>0 and slot[head_ptr].filled. inst/inst_pc driven from slot[head_ptr].
- Dequeue when inst_e_ low and dec_stall_ high: head_ptr++. inst/inst_pc stay stable while dec_stall_ low.
- used: +1 on accept, −1 on dequeue; unchanged when both occur in the same cycle.
- Full (used==DEPTH): no request; fetch_stall_ low. A dequeue in that cycle frees the slot for the next cycle only; there is no same-cycle refill.
- Latency: response at cycle N → inst_e_ low at N+1 (no bypass).
- Flush (flush_ low), highest priority:
  - All pointers and used cleared; all filled bits cleared.
  - discard <= (requests allocated but not yet filled) + (1 if a request is accepted this cycle; not possible, since ic_req_ is gated) − (1 if a non-discarded response arrives this cycle).
  - fetch_pc<=next_fetch_pc; inst_e_ high next cycle.
  - Any response in the flush cycle is not written.
- Flush while discard>0: new discard = old discard − (response this cycle) + pending unfilled (0 after the previous flush plus any since).
- Requests resume the cycle after flush, even while discard>0. Slots allocated after the flush are filled only after discard reaches 0.
- Assertions (sim only):
  - Response with no pending unfilled slot and discard==0 is an error.
  - used>DEPTH is an error.

Optional Feature:
- FETCH_BUF_BYPASS_EN defined: when the head slot is the fill target (slot[head_ptr] unfilled, fill_ptr==head_ptr), discard==0 and ic_resp_e_ low, then inst_e_ goes low in the same cycle with inst=ic_inst.
  - If dec_stall_ is high, the slot is consumed without being marked filled and head_ptr/fill_ptr both advance.
  - If dec_stall_ is low, the slot is written normally.
  - Response-to-decode latency 0.
- Undefined: latency 1 as above; no combinational path from ic_* to inst_e_/inst.

Test Plan:
- Reset then ic_ready=1 and responses one cycle after each request; next_fetch_pc=fetch_pc+4 → ic_addr 0,4,8,…; inst_e_ low from cycle 2 with inst_pc 0,4,8 in order.
- dec_stall_ low, responses held back → exactly 4 requests (0,4,8,C), then ic_req_ high and fetch_stall_ low. Release dec_stall_ → one new request per dequeue, with no duplicates and no skipped PCs.
- ic_ready=0 for 3 cycles → fetch_stall_ low, fetch_pc held at 0x10 and ic_addr stable; ic_ready=1 → request 0x10 accepted, fetch_pc=0x14.
- 3 requests outstanding (0,4,8), flush_ low with next_fetch_pc=0x100 → next request address 0x100; the 3 late responses are dropped; the first inst delivered has inst_pc=0x100.
- Flush in the same cycle as a response and a dequeue → discard equals the remaining unfilled count; no stale inst reaches decode; used=0 after flush.
- Assert reset_ low mid-stream, asynchronously and not clock aligned → outputs take reset values immediately; after release, fetch_pc=RESET_PC, and with FETCH_BUF_BYPASS_EN the first response appears on inst in the same cycle.
